// File: rtl/reg_bus_pkg.sv
// Shared constants for the register-bus read controller: FSM state
// encoding, state register width and settle counter width.
package reg_bus_pkg;

    localparam int STATE_W      = 2;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RESP    = 2'd2,
        SAMPLE2 = 2'd3
    } state_t;

endpackage

// File: rtl/reg_bus_settle_cnt.sv
// Loadable settle down-counter. A load or decrement only takes effect on
// a Tick cycle. Zero is the terminal-count flag the controller compares against.
module reg_bus_settle_cnt #(
    parameter int Width = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             Load,
    input  logic [Width-1:0] LoadValue,
    input  logic             Dec,
    output logic             Zero
);

    logic [Width-1:0] count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (Tick) begin
            if (Load) begin
                count <= LoadValue;
            end else if (Dec && (count != '0)) begin
                count <= count - Width'(1);
            end
        end
    end

    assign Zero = (count == '0);

endmodule

// File: rtl/reg_bus_read_ctrl.sv
// Read-side initiator for the shared tri-state register bus.
// Accepts one read request, pulls exactly one active-low select, waits
// SettleCycles extra Tick cycles, samples the bus and returns the data on a
// valid/ready response port.
// Optional build macro: REG_BUS_DOUBLE_SAMPLE_EN -- samples the bus on two
// consecutive Tick cycles and flags RspErr when the two samples disagree.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request in flight, all selects released, ReqReady high
// DRIVE   | one select low, counting down the settle time
// SAMPLE2 | (double-sample build) first sample taken, select still low
// RESP    | response held on RspValid until the consumer takes it
module reg_bus_read_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int SelBits      = 2,
    parameter int SettleCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                ReqValid,
    input  logic [SelBits-1:0]  ReqAddr,
    output logic                ReqReady,
    output logic [NrOfRegs-1:0] cs,
    input  logic [NrOfBits-1:0] BusData,
    output logic                RspValid,
    output logic [NrOfBits-1:0] RspData,
    output logic [SelBits-1:0]  RspAddr,
    output logic                RspErr,
    input  logic                RspReady
);

    state_t              state;
    logic                addr_in_range;
    logic [NrOfRegs-1:0] cs_decode;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

`ifdef REG_BUS_DOUBLE_SAMPLE_EN
    logic [NrOfBits-1:0] first_sample;
`endif

    // Address range check and one-cold select decode of the request index.
    always_comb begin
        addr_in_range = (int'(ReqAddr) < NrOfRegs);
        cs_decode     = '1;
        for (int i = 0; i < NrOfRegs; i++) begin
            cs_decode[i] = (int'(ReqAddr) != i);
        end
    end

    assign ReqReady = (state == IDLE);
    assign cnt_load = (state == IDLE) && ReqValid && addr_in_range;
    assign cnt_dec  = (state == DRIVE);

    reg_bus_settle_cnt #(
        .Width (SETTLE_CNT_W)
    ) u_settle_cnt (
        .Clock     (Clock),
        .Reset     (Reset),
        .Tick      (Tick),
        .Load      (cnt_load),
        .LoadValue (SETTLE_CNT_W'(SettleCycles)),
        .Dec       (cnt_dec),
        .Zero      (cnt_zero)
    );

    // Sequencing FSM with registered select and response outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cs       <= '1;
            RspValid <= 1'b0;
            RspData  <= '0;
            RspAddr  <= '0;
            RspErr   <= 1'b0;
`ifdef REG_BUS_DOUBLE_SAMPLE_EN
            first_sample <= '0;
`endif
        end else if (Tick) begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        RspAddr <= ReqAddr;
                        if (addr_in_range) begin
                            cs    <= cs_decode;
                            state <= DRIVE;
                        end else begin
                            RspData  <= '0;
                            RspErr   <= 1'b1;
                            RspValid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
`ifdef REG_BUS_DOUBLE_SAMPLE_EN
                        first_sample <= BusData;
                        state        <= SAMPLE2;
`else
                        RspData  <= BusData;
                        RspErr   <= 1'b0;
                        cs       <= '1;
                        RspValid <= 1'b1;
                        state    <= RESP;
`endif
                    end
                end
`ifdef REG_BUS_DOUBLE_SAMPLE_EN
                SAMPLE2: begin
                    RspData  <= BusData;
                    RspErr   <= (BusData != first_sample);
                    cs       <= '1;
                    RspValid <= 1'b1;
                    state    <= RESP;
                end
`endif
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    cs    <= '1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
